mem_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single CPU-style valid/ready memory bus, which feeds the top-level address decoder, between the picorv32 (master 0) and a secondary bus master (master 1, e.g. a DMA or debug engine). Only one master at a time gets access to the ROM/RAM/MMIO decoder. The block applies priority with round-robin fairness and holds a grant for exactly one transaction. It inserts a release cycle so masters can drop `valid`. A watchdog completes any transaction the slave side fails to acknowledge, and the block reports bus timeouts.

---
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one valid/ready memory bus between two masters (0: picorv32,
//   1: secondary master). Ties go to the master not granted last, and a grant
//   covers exactly one transaction. A RELEASE cycle follows each completion so
//   the master can drop valid. A watchdog completes any transaction the slave
//   never acknowledges, returning ERROR_RDATA and counting the timeout.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   mX_valid/addr/wdata/wstrb/instr   master X request (wstrb == 0 is a read)
//   mX_ready, mX_rdata          master X completion pulse and read data
//   s_valid/addr/wdata/wstrb/instr    request forwarded to the decoder
//   s_ready, s_rdata            decoder completion and read data
//   timeout_flag                sticky timeout indicator
//   timeout_count               saturating timeout counter
//   timeout_clear               clears flag and counter (wins over a new timeout)

module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERROR_RDATA    = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   input  logic        m0_instr,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   input  logic        m1_instr,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   output logic        s_instr,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic        timeout_flag,
   output logic [7:0]  timeout_count,
   input  logic        timeout_clear
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RELEASE
   } state_t;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        owner;
   logic        last;
   logic [15:0] wd_ctr;

   logic        owner_valid;
   logic        wd_expired;
   logic        timeout_hit;
   logic        winner;

   always_comb begin
      owner_valid = owner ? m1_valid : m0_valid;
      wd_expired  = (wd_ctr == WD_LAST);
      // s_ready takes precedence over an expiring watchdog in the same cycle.
      timeout_hit = (state == BUSY) && owner_valid && !s_ready && wd_expired;
      // Single requester wins outright; a tie goes to the master not granted last.
      winner      = (m0_valid && m1_valid) ? !last : m1_valid;
   end

   // Bus-facing outputs are combinational from state/owner so a zero-wait
   // decoder completes in the first BUSY cycle.
   always_comb begin
      s_valid  = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      s_instr  = 1'b0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
      if (state == BUSY) begin
         s_addr  = owner ? m1_addr  : m0_addr;
         s_wdata = owner ? m1_wdata : m0_wdata;
         s_wstrb = owner ? m1_wstrb : m0_wstrb;
         s_instr = owner ? m1_instr : m0_instr;
         if (owner_valid) begin
            if (s_ready) begin
               s_valid = 1'b1;
               if (owner) begin
                  m1_ready = 1'b1;
                  m1_rdata = s_rdata;
               end else begin
                  m0_ready = 1'b1;
                  m0_rdata = s_rdata;
               end
            end else if (wd_expired) begin
               if (owner) begin
                  m1_ready = 1'b1;
                  m1_rdata = ERROR_RDATA;
               end else begin
                  m0_ready = 1'b1;
                  m0_rdata = ERROR_RDATA;
               end
            end else begin
               s_valid = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last          <= 1'b1;
         wd_ctr        <= '0;
         timeout_flag  <= 1'b0;
         timeout_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_valid || m1_valid) begin
                  owner  <= winner;
                  last   <= winner;
                  wd_ctr <= '0;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (!owner_valid) begin
                  state <= IDLE;
               end else if (s_ready || wd_expired) begin
                  state <= RELEASE;
               end else begin
                  wd_ctr <= wd_ctr + 16'd1;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (timeout_clear) begin
            timeout_flag  <= 1'b0;
            timeout_count <= '0;
         end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
            if (timeout_count != 8'hFF) begin
               timeout_count <= timeout_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter (TIMEOUT_CYCLES = 4). Inputs change on
//   the falling edge; outputs are sampled 1 ns later, i.e. they reflect the
//   state registered at the preceding rising edge.

module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_instr, m1_instr;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_instr;
   logic        s_ready;
   logic [31:0] s_rdata;
   logic        timeout_flag;
   logic [7:0]  timeout_count;
   logic        timeout_clear;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES(4),
      .ERROR_RDATA   (32'h0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .m0_valid     (m0_valid),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_wstrb     (m0_wstrb),
      .m0_instr     (m0_instr),
      .m0_ready     (m0_ready),
      .m0_rdata     (m0_rdata),
      .m1_valid     (m1_valid),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_wstrb     (m1_wstrb),
      .m1_instr     (m1_instr),
      .m1_ready     (m1_ready),
      .m1_rdata     (m1_rdata),
      .s_valid      (s_valid),
      .s_addr       (s_addr),
      .s_wdata      (s_wdata),
      .s_wstrb      (s_wstrb),
      .s_instr      (s_instr),
      .s_ready      (s_ready),
      .s_rdata      (s_rdata),
      .timeout_flag (timeout_flag),
      .timeout_count(timeout_count),
      .timeout_clear(timeout_clear)
   );

   task automatic clear_inputs();
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0; m0_instr = 1'b0;
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0; m1_instr = 1'b0;
      s_ready = 1'b0; s_rdata = '0; timeout_clear = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      clear_inputs();
      reset = 1'b1;
      s_ready = 1'b1;
      s_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      #1;
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rst_s_valid got=%h exp=0", s_valid); end
      total++; if (s_addr !== 32'h0) begin bad++; $display("FAIL rst_s_addr got=%h exp=0", s_addr); end
      total++; if ({s_wdata, s_wstrb, s_instr} !== 37'h0) begin bad++; $display("FAIL rst_s_misc got=%h exp=0", {s_wdata, s_wstrb, s_instr}); end
      total++; if ({m0_ready, m1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", {m0_ready, m1_ready}); end
      total++; if ({m0_rdata, m1_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
      total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL rst_tflag got=%b exp=0", timeout_flag); end
      total++; if (timeout_count !== 8'd0) begin bad++; $display("FAIL rst_tcount got=%0d exp=0", timeout_count); end
      reset = 1'b0;
      clear_inputs();
   endtask

   task automatic test_single_read();
      do_reset();
      // IDLE: request presented
      @(negedge clk);
      m0_valid = 1'b1; m0_addr = 32'h4000_0010; m0_wstrb = 4'h0;
      #1;
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rd_idle_svalid got=%b exp=0", s_valid); end
      // BUSY, decoder wait state
      @(negedge clk);
      #1;
      total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rd_busy_svalid got=%b exp=1", s_valid); end
      total++; if (s_addr !== 32'h4000_0010) begin bad++; $display("FAIL rd_busy_addr got=%h exp=40000010", s_addr); end
      total++; if ({m0_ready, m1_ready} !== 2'b00) begin bad++; $display("FAIL rd_wait_ready got=%b exp=00", {m0_ready, m1_ready}); end
      // BUSY, decoder completes
      @(negedge clk);
      s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
      #1;
      total++; if (m0_ready !== 1'b1) begin bad++; $display("FAIL rd_m0_ready got=%b exp=1", m0_ready); end
      total++; if (m0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_m0_rdata got=%h exp=deadbeef", m0_rdata); end
      total++; if ({m1_ready, m1_rdata} !== 33'h0) begin bad++; $display("FAIL rd_m1_quiet got=%h exp=0", {m1_ready, m1_rdata}); end
      // RELEASE: master still holding valid, decoder ready still high
      @(negedge clk);
      #1;
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rd_rel_svalid got=%b exp=0", s_valid); end
      total++; if ({m0_ready, m1_ready} !== 2'b00) begin bad++; $display("FAIL rd_rel_ready got=%b exp=00", {m0_ready, m1_ready}); end
      total++; if (m0_rdata !== 32'h0) begin bad++; $display("FAIL rd_rel_rdata got=%h exp=0", m0_rdata); end
      // IDLE again after release
      @(negedge clk);
      m0_valid = 1'b0; s_ready = 1'b0;
      #1;
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rd_idle2_svalid got=%b exp=0", s_valid); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_round_robin();
      logic        exp_own;
      logic [31:0] exp_addr, exp_wdata, exp_rd;
      logic [3:0]  exp_wstrb;
      logic        exp_instr;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         exp_own   = (k % 2) == 1;
         exp_addr  = exp_own ? 32'h2000_0200 : 32'h0000_1000;
         exp_wdata = exp_own ? 32'h5555_1111 : 32'hAAAA_0000;
         exp_wstrb = exp_own ? 4'b1100 : 4'b1111;
         exp_instr = exp_own ? 1'b0 : 1'b1;
         exp_rd    = 32'h1000_0000 + 32'(k);
         @(negedge clk);
         m0_valid = 1'b1; m0_addr = 32'h0000_1000; m0_wdata = 32'hAAAA_0000; m0_wstrb = 4'b1111; m0_instr = 1'b1;
         m1_valid = 1'b1; m1_addr = 32'h2000_0200; m1_wdata = 32'h5555_1111; m1_wstrb = 4'b1100; m1_instr = 1'b0;
         s_ready = 1'b1; s_rdata = exp_rd;
         #1;
         total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rr%0d_idle_svalid got=%b exp=0", k, s_valid); end
         @(negedge clk);
         #1;
         total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rr%0d_svalid got=%b exp=1", k, s_valid); end
         total++; if (s_addr !== exp_addr) begin bad++; $display("FAIL rr%0d_addr got=%h exp=%h", k, s_addr, exp_addr); end
         total++; if (s_wdata !== exp_wdata) begin bad++; $display("FAIL rr%0d_wdata got=%h exp=%h", k, s_wdata, exp_wdata); end
         total++; if (s_wstrb !== exp_wstrb) begin bad++; $display("FAIL rr%0d_wstrb got=%b exp=%b", k, s_wstrb, exp_wstrb); end
         total++; if (s_instr !== exp_instr) begin bad++; $display("FAIL rr%0d_instr got=%b exp=%b", k, s_instr, exp_instr); end
         total++; if ({m1_ready, m0_ready} !== {exp_own, !exp_own}) begin bad++; $display("FAIL rr%0d_ready got=%b exp=%b", k, {m1_ready, m0_ready}, {exp_own, !exp_own}); end
         total++; if ((exp_own ? m1_rdata : m0_rdata) !== exp_rd) begin bad++; $display("FAIL rr%0d_rdata got=%h exp=%h", k, exp_own ? m1_rdata : m0_rdata, exp_rd); end
         total++; if ((exp_own ? m0_rdata : m1_rdata) !== 32'h0) begin bad++; $display("FAIL rr%0d_other_rdata got=%h exp=0", k, exp_own ? m0_rdata : m1_rdata); end
         @(negedge clk);
         #1;
         total++; if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin bad++; $display("FAIL rr%0d_rel got=%b exp=000", k, {s_valid, m0_ready, m1_ready}); end
         total++; if ({s_addr, s_wstrb} !== 36'h0) begin bad++; $display("FAIL rr%0d_rel_bus got=%h exp=0", k, {s_addr, s_wstrb}); end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_m1_write();
      do_reset();
      @(negedge clk);
      m1_valid = 1'b1; m1_addr = 32'h2000_0004; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011; m1_instr = 1'b0;
      m0_wdata = 32'hFFFF_FFFF; m0_wstrb = 4'b1111;
      #1;
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL wr_idle_svalid got=%b exp=0", s_valid); end
      @(negedge clk);
      s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
      #1;
      total++; if (s_wstrb !== 4'b0011) begin bad++; $display("FAIL wr_wstrb got=%b exp=0011", s_wstrb); end
      total++; if (s_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_wdata got=%h exp=12345678", s_wdata); end
      total++; if (s_addr !== 32'h2000_0004) begin bad++; $display("FAIL wr_addr got=%h exp=20000004", s_addr); end
      total++; if (m1_ready !== 1'b1) begin bad++; $display("FAIL wr_m1_ready got=%b exp=1", m1_ready); end
      total++; if ({m0_ready, m0_rdata} !== 33'h0) begin bad++; $display("FAIL wr_m0_quiet got=%h exp=0", {m0_ready, m0_rdata}); end
      @(negedge clk);
      m1_valid = 1'b0; s_ready = 1'b0;
      #1;
      total++; if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin bad++; $display("FAIL wr_rel got=%b exp=000", {s_valid, m0_ready, m1_ready}); end
      @(negedge clk);
      clear_inputs();
   endtask

   // One full timed-out transaction from master 0: IDLE, four BUSY cycles,
   // RELEASE. mask bit c records m0_ready in cycle c.
   task automatic one_timeout(input logic clr, output logic [5:0] mask, output logic [31:0] rd);
      mask = '0;
      rd   = 32'hFFFF_FFFF;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         m0_valid = 1'b1; m0_addr = 32'h3000_0000;
         s_ready = 1'b0; s_rdata = 32'hBADD_F00D;
         timeout_clear = (c == 4) ? clr : 1'b0;
         #1;
         mask[c] = m0_ready;
         if (m0_ready) rd = m0_rdata;
      end
      timeout_clear = 1'b0;
   endtask

   task automatic test_timeout();
      logic [5:0]  mask;
      logic [31:0] rd;
      do_reset();
      one_timeout(1'b0, mask, rd);
      total++; if (mask !== 6'b010000) begin bad++; $display("FAIL to_ready_cycle got=%b exp=010000", mask); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", rd); end
      total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL to_flag1 got=%b exp=1", timeout_flag); end
      total++; if (timeout_count !== 8'd1) begin bad++; $display("FAIL to_count1 got=%0d exp=1", timeout_count); end
      for (int i = 1; i < 255; i++) one_timeout(1'b0, mask, rd);
      total++; if (timeout_count !== 8'd255) begin bad++; $display("FAIL to_count255 got=%0d exp=255", timeout_count); end
      one_timeout(1'b0, mask, rd);
      total++; if (timeout_count !== 8'd255) begin bad++; $display("FAIL to_count_sat got=%0d exp=255", timeout_count); end
      total++; if (mask !== 6'b010000) begin bad++; $display("FAIL to_sat_ready got=%b exp=010000", mask); end
      // explicit clear while idle
      @(negedge clk);
      m0_valid = 1'b0; timeout_clear = 1'b1;
      @(negedge clk);
      timeout_clear = 1'b0;
      #1;
      total++; if ({timeout_flag, timeout_count} !== 9'h0) begin bad++; $display("FAIL to_clear got=%h exp=0", {timeout_flag, timeout_count}); end
      // clear coinciding with a timeout: clear wins, master still completes
      one_timeout(1'b1, mask, rd);
      total++; if (mask !== 6'b010000) begin bad++; $display("FAIL to_clr_ready got=%b exp=010000", mask); end
      total++; if ({timeout_flag, timeout_count} !== 9'h0) begin bad++; $display("FAIL to_clr_wins got=%h exp=0", {timeout_flag, timeout_count}); end
      one_timeout(1'b0, mask, rd);
      total++; if ({timeout_flag, timeout_count} !== {1'b1, 8'd1}) begin bad++; $display("FAIL to_after_clr got=%h exp=101", {timeout_flag, timeout_count}); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid_busy();
      // timeout_flag/count are non-zero on entry (left by test_timeout)
      @(negedge clk);
      clear_inputs();
      m0_valid = 1'b1; m0_addr = 32'h4000_0020;
      @(negedge clk);
      #1;
      total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rb_busy got=%b exp=1", s_valid); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if ({m0_ready, m1_ready} !== 2'b00) begin bad++; $display("FAIL rb_no_ready got=%b exp=00", {m0_ready, m1_ready}); end
      @(negedge clk);
      reset = 1'b0;
      m1_valid = 1'b1; m1_addr = 32'h5000_0000;
      #1;
      total++; if ({s_valid, s_addr, m0_ready, m1_ready} !== 35'h0) begin bad++; $display("FAIL rb_outputs got=%h exp=0", {s_valid, s_addr, m0_ready, m1_ready}); end
      total++; if ({m0_rdata, m1_rdata} !== 64'h0) begin bad++; $display("FAIL rb_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
      total++; if ({timeout_flag, timeout_count} !== 9'h0) begin bad++; $display("FAIL rb_timeout_regs got=%h exp=0", {timeout_flag, timeout_count}); end
      // tie after reset goes to master 0
      @(negedge clk);
      s_ready = 1'b1; s_rdata = 32'h1111_2222;
      #1;
      total++; if (s_addr !== 32'h4000_0020) begin bad++; $display("FAIL rb_tie_addr got=%h exp=40000020", s_addr); end
      total++; if ({m0_ready, m1_ready} !== 2'b10) begin bad++; $display("FAIL rb_tie_ready got=%b exp=10", {m0_ready, m1_ready}); end
      @(negedge clk);
      m0_valid = 1'b0; s_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      s_ready = 1'b1; s_rdata = 32'h3333_4444;
      #1;
      total++; if (s_addr !== 32'h5000_0000) begin bad++; $display("FAIL rb_m1_addr got=%h exp=50000000", s_addr); end
      total++; if ({m1_ready, m1_rdata} !== {1'b1, 32'h3333_4444}) begin bad++; $display("FAIL rb_m1_ready got=%h exp=133334444", {m1_ready, m1_rdata}); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_abort();
      do_reset();
      @(negedge clk);
      m0_valid = 1'b1; m0_addr = 32'h6000_0000;
      @(negedge clk);
      #1;
      total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL ab_busy got=%b exp=1", s_valid); end
      @(negedge clk);
      m0_valid = 1'b0;
      #1;
      total++; if ({s_valid, m0_ready} !== 2'b00) begin bad++; $display("FAIL ab_drop got=%b exp=00", {s_valid, m0_ready}); end
      // next cycle must be IDLE: a new m1 request is granted here
      @(negedge clk);
      m1_valid = 1'b1; m1_addr = 32'h7000_0004; s_ready = 1'b1; s_rdata = 32'h0BAD_CAFE;
      #1;
      total++; if ({s_valid, m0_ready, m1_ready} !== 3'b000) begin bad++; $display("FAIL ab_idle got=%b exp=000", {s_valid, m0_ready, m1_ready}); end
      @(negedge clk);
      #1;
      total++; if ({s_valid, m1_ready} !== 2'b11) begin bad++; $display("FAIL ab_m1_grant got=%b exp=11", {s_valid, m1_ready}); end
      total++; if (s_addr !== 32'h7000_0004) begin bad++; $display("FAIL ab_m1_addr got=%h exp=70000004", s_addr); end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_m1_write();
      test_timeout();
      test_reset_mid_busy();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
